// File: rtl/falu_seq.sv
// Sequencer for a multi-cycle FP arithmetic unit: accepts one request at a time,
// waits the opcode's fixed latency, then holds the result until it is consumed.
package falu_seq_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned OPC_W  = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 3'b000,
    OP_SQRT = 3'b001,
    OP_FADD = 3'b010,
    OP_FSUB = 3'b011,
    OP_FMUL = 3'b100,
    OP_FDIV = 3'b101,
    OP_FMIN = 3'b110,
    OP_FMAX = 3'b111
  } op_e;

  // Everything latched from the request channel at acceptance.
  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [OPC_W-1:0]  opcode;
    logic              wid;
    logic [TAG_W-1:0]  tag;
  } req_t;

endpackage

module falu_seq
  import falu_seq_pkg::*;
#(
  parameter int unsigned LAT_MINMAX = 1,
  parameter int unsigned LAT_ADD    = 3,
  parameter int unsigned LAT_MUL    = 4,
  parameter int unsigned LAT_DIV    = 20,
  parameter int unsigned LAT_SQRT   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  input  logic [OPC_W-1:0]  req_opcode,
  input  logic              req_wid,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] falu_op1,
  output logic [DATA_W-1:0] falu_op2,
  output logic [OPC_W-1:0]  falu_opcode,
  output logic              falu_wid,
  input  logic [DATA_W-1:0] falu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  input  logic              flush,
  output logic              busy,
  output logic [15:0]       op_count
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned OPCNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  req_t                 op_q, op_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic [OPCNT_W-1:0]   op_count_q, op_count_d;
  logic                 accept;

  // Fixed latency per opcode; NOP still takes one EXEC edge.
  function automatic logic [CNT_W-1:0] lat_of(input logic [OPC_W-1:0] opc);
    logic [CNT_W-1:0] lat;
    case (opc)
      OP_SQRT:          lat = CNT_W'(LAT_SQRT);
      OP_FADD, OP_FSUB: lat = CNT_W'(LAT_ADD);
      OP_FMUL:          lat = CNT_W'(LAT_MUL);
      OP_FDIV:          lat = CNT_W'(LAT_DIV);
      OP_FMIN, OP_FMAX: lat = CNT_W'(LAT_MINMAX);
      default:          lat = CNT_W'(1);
    endcase
    return lat;
  endfunction

  assign req_ready = (state_q == IDLE) & ~flush;
  assign accept    = req_valid & req_ready;

  // Next-state and datapath update; flush outranks completion and handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d.op1    = req_op1;
          op_d.op2    = req_op2;
          op_d.opcode = req_opcode;
          op_d.wid    = req_wid;
          op_d.tag    = req_tag;
          cnt_d       = lat_of(req_opcode);
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          rsp_data_d = (op_q.opcode == OP_NOP) ? '0 : falu_out;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (rsp_ready) begin
          op_count_d = op_count_q + OPCNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      op_count_q <= op_count_d;
    end
  end

  // Operand latches feed the unit continuously; only the opcode is masked when idle.
  assign falu_op1    = op_q.op1;
  assign falu_op2    = op_q.op2;
  assign falu_wid    = op_q.wid;
  assign falu_opcode = (state_q == IDLE) ? OP_NOP : op_q.opcode;

  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = op_q.tag;
  assign busy      = (state_q != IDLE);
  assign op_count  = op_count_q;

endmodule
